// File: rtl/mem_wdata_fwd_unit.sv
// MEM-stage store-data forwarding: wb bus, write history or load hold register,
// with load-wait stall, size replication and byte strobe generation.
module mem_wdata_fwd_unit #(
    parameter int XLEN     = 32,
    parameter int REG_AW   = 5,
    parameter int DEPTH    = 2,
    parameter bit ALIGN_EN = 1'b1,
    localparam int NB      = XLEN / 8,
    localparam int AW      = $clog2(NB)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              lp_valid,
    input  logic [REG_AW-1:0] lp_rd,
    input  logic              mem_valid,
    input  logic              mem_is_store,
    input  logic [REG_AW-1:0] mem_rs2,
    input  logic [XLEN-1:0]   mem_rs2_data,
    input  logic [1:0]        mem_size,
    input  logic [AW-1:0]     mem_addr_lo,
    input  logic              mem_advance,
    output logic [XLEN-1:0]   mem_wdata_o,
    output logic [NB-1:0]     mem_wstrb_o,
    output logic [1:0]        fwd_src_o,
    output logic              stall_o,
    output logic [15:0]       wait_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_READY
    } state_t;

    state_t state_q, state_d;

    logic [REG_AW-1:0]            wait_rd_q;
    logic [XLEN-1:0]              hold_q;
    logic [15:0]                  cnt_q;
    logic [DEPTH-1:0]             hv_q;
    logic [DEPTH-1:0][REG_AW-1:0] hrd_q;
    logic [DEPTH-1:0][XLEN-1:0]   hdata_q;

    logic            store_act;
    logic            st_valid;
    logic            wb_hit;
    logic            wait_enter;
    logic            ld_ret;
    logic            push;
    logic            hist_hit;
    logic [XLEN-1:0] hist_data;
    logic [XLEN-1:0] sel_data;

    assign st_valid   = mem_valid & mem_is_store;
    assign store_act  = st_valid & (mem_rs2 != '0);
    assign wb_hit     = store_act & wb_valid & (wb_rd == mem_rs2);
    assign wait_enter = store_act & lp_valid & (lp_rd == mem_rs2) & ~wb_hit;
    assign ld_ret     = wb_valid & (wb_rd == wait_rd_q);
    assign push       = wb_valid & (wb_rd != '0);

    // Scan oldest to youngest so the youngest matching entry wins.
    always_comb begin
        hist_hit  = 1'b0;
        hist_data = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (hv_q[i] && hrd_q[i] == mem_rs2) begin
                hist_hit  = 1'b1;
                hist_data = hdata_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hv_q    <= '0;
            hrd_q   <= '0;
            hdata_q <= '0;
        end else if (push) begin
            hv_q[0]    <= 1'b1;
            hrd_q[0]   <= wb_rd;
            hdata_q[0] <= wb_data;
            for (int i = 1; i < DEPTH; i++) begin
                hv_q[i]    <= hv_q[i-1];
                hrd_q[i]   <= hrd_q[i-1];
                hdata_q[i] <= hdata_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE:  if (wait_enter)  state_d = ST_WAIT;
                ST_WAIT:  if (ld_ret)      state_d = ST_READY;
                ST_READY: if (mem_advance) state_d = ST_IDLE;
                default:                   state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        stall_o = ((state_q == ST_IDLE) & wait_enter) | (state_q == ST_WAIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_rd_q <= '0;
            hold_q    <= '0;
            cnt_q     <= '0;
        end else begin
            if (state_q == ST_IDLE && wait_enter) wait_rd_q <= mem_rs2;
            if (flush)                              hold_q <= '0;
            else if (state_q == ST_WAIT && ld_ret) hold_q <= wb_data;
            if (stall_o && !flush && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
        end
    end

    assign wait_cnt_o = cnt_q;

    always_comb begin
        fwd_src_o = 2'd0;
        sel_data  = mem_rs2_data;
        if (mem_rs2 != '0) begin
            if (state_q == ST_READY) begin
                fwd_src_o = 2'd3;
                sel_data  = hold_q;
            end else if (wb_hit) begin
                fwd_src_o = 2'd1;
                sel_data  = wb_data;
            end else if (store_act && hist_hit) begin
                fwd_src_o = 2'd2;
                sel_data  = hist_data;
            end
        end
    end

    logic [1:0]      sz;
    logic [AW-1:0]   off;
    logic [NB-1:0]   mask;
    logic [XLEN-1:0] rep;

    // A doubleword on a 32-bit datapath degrades to a word access.
    always_comb begin
        sz = (XLEN == 32 && mem_size == 2'd3) ? 2'd2 : mem_size;
        unique case (sz)
            2'd0: begin
                rep  = {NB{sel_data[7:0]}};
                mask = NB'(1);
            end
            2'd1: begin
                rep  = {(NB/2){sel_data[15:0]}};
                mask = NB'(3);
            end
            2'd2: begin
                rep  = {(NB/4){sel_data[31:0]}};
                mask = NB'(15);
            end
            default: begin
                rep  = sel_data;
                mask = '1;
            end
        endcase
        off = mem_addr_lo & ~AW'((1 << sz) - 1);
        if (ALIGN_EN) begin
            mem_wdata_o = rep;
            mem_wstrb_o = st_valid ? NB'(mask << off) : '0;
        end else begin
            mem_wdata_o = sel_data;
            mem_wstrb_o = st_valid ? '1 : '0;
        end
    end

endmodule

// File: tb/tb_mem_wdata_fwd_unit.sv
// Scoreboard bench for mem_wdata_fwd_unit: a 32-bit DEPTH=2 unit and a
// 64-bit DEPTH=1 unit share the same stimulus.
module tb_mem_wdata_fwd_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        lp_valid;
    logic [4:0]  lp_rd;
    logic        mem_valid;
    logic        mem_is_store;
    logic [4:0]  mem_rs2;
    logic [63:0] rs2_data;
    logic [1:0]  mem_size;
    logic [2:0]  addr_lo;
    logic        mem_advance;

    logic [31:0] wdata32;
    logic [3:0]  wstrb32;
    logic [1:0]  src32;
    logic        stall32;
    logic [15:0] cnt32;
    logic [63:0] wdata64;
    logic [7:0]  wstrb64;
    logic [1:0]  src64;
    logic        stall64;
    logic [15:0] cnt64;

    always #5 clk = ~clk;

    mem_wdata_fwd_unit #(.XLEN(32), .DEPTH(2)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data[31:0]),
        .lp_valid(lp_valid), .lp_rd(lp_rd),
        .mem_valid(mem_valid), .mem_is_store(mem_is_store),
        .mem_rs2(mem_rs2), .mem_rs2_data(rs2_data[31:0]),
        .mem_size(mem_size), .mem_addr_lo(addr_lo[1:0]),
        .mem_advance(mem_advance),
        .mem_wdata_o(wdata32), .mem_wstrb_o(wstrb32),
        .fwd_src_o(src32), .stall_o(stall32), .wait_cnt_o(cnt32)
    );

    mem_wdata_fwd_unit #(.XLEN(64), .DEPTH(1)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .lp_valid(lp_valid), .lp_rd(lp_rd),
        .mem_valid(mem_valid), .mem_is_store(mem_is_store),
        .mem_rs2(mem_rs2), .mem_rs2_data(rs2_data),
        .mem_size(mem_size), .mem_addr_lo(addr_lo),
        .mem_advance(mem_advance),
        .mem_wdata_o(wdata64), .mem_wstrb_o(wstrb64),
        .fwd_src_o(src64), .stall_o(stall64), .wait_cnt_o(cnt64)
    );

    typedef struct packed {
        logic        d64;
        logic [4:0]  m;
        logic [63:0] data;
        logic [7:0]  strb;
        logic [1:0]  src;
        logic        stall;
        logic [15:0] cnt;
    } exp_t;

    localparam logic [4:0] M_D = 5'd1;
    localparam logic [4:0] M_S = 5'd2;
    localparam logic [4:0] M_F = 5'd4;
    localparam logic [4:0] M_T = 5'd8;
    localparam logic [4:0] M_C = 5'd16;
    localparam logic [4:0] M_A = 5'd31;

    exp_t        sb[$];
    exp_t        e;
    int          n_chk  = 0;
    int          n_pass = 0;
    int          n_vec  = 0;
    string       pfx;
    logic [63:0] o_data;
    logic [7:0]  o_strb;
    logic [1:0]  o_src;
    logic        o_stall;
    logic [15:0] o_cnt;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    task automatic push(input logic d64, input logic [4:0] m,
                        input logic [63:0] data, input logic [7:0] strb,
                        input logic [1:0] src, input logic stall,
                        input logic [15:0] cnt);
        exp_t x;
        x.d64   = d64;
        x.m     = m;
        x.data  = data;
        x.strb  = strb;
        x.src   = src;
        x.stall = stall;
        x.cnt   = cnt;
        sb.push_back(x);
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_vec++;
            pfx     = e.d64 ? "x64" : "x32";
            o_data  = e.d64 ? wdata64 : {32'h0, wdata32};
            o_strb  = e.d64 ? wstrb64 : {4'h0, wstrb32};
            o_src   = e.d64 ? src64 : src32;
            o_stall = e.d64 ? stall64 : stall32;
            o_cnt   = e.d64 ? cnt64 : cnt32;
            if (e.m[0]) chk($sformatf("v%0d_%s_wdata", n_vec, pfx), o_data, e.data);
            if (e.m[1]) chk($sformatf("v%0d_%s_wstrb", n_vec, pfx), 64'(o_strb), 64'(e.strb));
            if (e.m[2]) chk($sformatf("v%0d_%s_src", n_vec, pfx), 64'(o_src), 64'(e.src));
            if (e.m[3]) chk($sformatf("v%0d_%s_stall", n_vec, pfx), 64'(o_stall), 64'(e.stall));
            if (e.m[4]) chk($sformatf("v%0d_%s_cnt", n_vec, pfx), 64'(o_cnt), 64'(e.cnt));
        end
    end

    task automatic idle();
        flush        = 1'b0;
        wb_valid     = 1'b0;
        wb_rd        = 5'd0;
        wb_data      = 64'h0;
        lp_valid     = 1'b0;
        lp_rd        = 5'd0;
        mem_valid    = 1'b0;
        mem_is_store = 1'b0;
        mem_rs2      = 5'd0;
        rs2_data     = 64'h0;
        mem_size     = 2'd2;
        addr_lo      = 3'd0;
        mem_advance  = 1'b0;
    endtask

    task automatic store(input logic [4:0] rs2, input logic [63:0] d,
                         input logic [1:0] sz, input logic [2:0] a);
        mem_valid    = 1'b1;
        mem_is_store = 1'b1;
        mem_rs2      = rs2;
        rs2_data     = d;
        mem_size     = sz;
        addr_lo      = a;
    endtask

    task automatic wb(input logic [4:0] rd, input logic [63:0] d);
        wb_valid = 1'b1;
        wb_rd    = rd;
        wb_data  = d;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        push(1'b0, M_A, 64'h0, 8'h0, 2'd0, 1'b0, 16'd0);
        push(1'b1, M_A, 64'h0, 8'h0, 2'd0, 1'b0, 16'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // live wb bus forwarding, also with a pending load to the same rd
        wb(5'd5, 64'hDEADBEEF);
        store(5'd5, 64'h12345678, 2'd2, 3'd0);
        push(1'b0, M_A, 64'hDEADBEEF, 8'hF, 2'd1, 1'b0, 16'd0);
        push(1'b1, M_D | M_S | M_F | M_T, 64'hDEADBEEF_DEADBEEF, 8'h0F, 2'd1, 1'b0, 16'd0);
        nxt();
        lp_valid = 1'b1;
        lp_rd    = 5'd5;
        wb(5'd5, 64'h5A5A0001);
        store(5'd5, 64'h0, 2'd2, 3'd0);
        push(1'b0, M_A, 64'h5A5A0001, 8'hF, 2'd1, 1'b0, 16'd0);
        nxt();
        push(1'b0, M_S | M_T | M_C, 64'h0, 8'h0, 2'd0, 1'b0, 16'd0);
        nxt();

        // history: youngest duplicate wins, depth limits
        do_reset();
        wb(5'd7, 64'h11);
        push(1'b0, M_S | M_F | M_T, 64'h0, 8'h0, 2'd0, 1'b0, 16'd0);
        nxt();
        wb(5'd7, 64'h22);
        nxt();
        store(5'd7, 64'hFFFF0000, 2'd2, 3'd0);
        push(1'b0, M_D | M_F, 64'h22, 8'h0, 2'd2, 1'b0, 16'd0);
        nxt();
        wb(5'd3, 64'h33);
        nxt();
        wb(5'd4, 64'h44);
        nxt();
        wb(5'd6, 64'h66);
        nxt();
        store(5'd6, 64'hCAFEF00D, 2'd2, 3'd0);
        push(1'b0, M_D | M_F, 64'h66, 8'h0, 2'd2, 1'b0, 16'd0);
        push(1'b1, M_D | M_F, 64'h00000066_00000066, 8'h0, 2'd2, 1'b0, 16'd0);
        nxt();
        store(5'd4, 64'hCAFEF00D, 2'd2, 3'd0);
        push(1'b0, M_D | M_F, 64'h44, 8'h0, 2'd2, 1'b0, 16'd0);
        push(1'b1, M_D | M_F, 64'hCAFEF00D_CAFEF00D, 8'h0, 2'd0, 1'b0, 16'd0);
        nxt();
        store(5'd3, 64'hCAFEF00D, 2'd2, 3'd0);
        push(1'b0, M_D | M_F, 64'hCAFEF00D, 8'h0, 2'd0, 1'b0, 16'd0);
        nxt();

        // pending load: 4 cycles of wait plus the return cycle
        do_reset();
        for (int i = 0; i < 4; i++) begin
            lp_valid = 1'b1;
            lp_rd    = 5'd9;
            store(5'd9, 64'h1, 2'd2, 3'd0);
            push(1'b0, M_T | M_C, 64'h0, 8'h0, 2'd0, 1'b1, 16'(i));
            nxt();
        end
        store(5'd9, 64'h1, 2'd2, 3'd0);
        wb(5'd9, 64'h01234567_A5A5A5A5);
        push(1'b0, M_T | M_C, 64'h0, 8'h0, 2'd0, 1'b1, 16'd4);
        nxt();
        store(5'd9, 64'h1, 2'd2, 3'd0);
        mem_advance = 1'b1;
        push(1'b0, M_A, 64'hA5A5A5A5, 8'hF, 2'd3, 1'b0, 16'd5);
        push(1'b1, M_D | M_F | M_T | M_C, 64'hA5A5A5A5_A5A5A5A5, 8'h0, 2'd3, 1'b0, 16'd5);
        nxt();
        store(5'd9, 64'h1, 2'd2, 3'd0);
        push(1'b0, M_D | M_F | M_T | M_C, 64'hA5A5A5A5, 8'h0, 2'd2, 1'b0, 16'd5);
        nxt();

        // size replication and strobes
        store(5'd10, 64'hC3, 2'd0, 3'd2);
        push(1'b0, M_D | M_S | M_F, 64'hC3C3C3C3, 8'h4, 2'd0, 1'b0, 16'd0);
        push(1'b1, M_D | M_S, 64'hC3C3C3C3_C3C3C3C3, 8'h04, 2'd0, 1'b0, 16'd0);
        nxt();
        store(5'd10, 64'hBEEF, 2'd1, 3'd2);
        push(1'b0, M_D | M_S, 64'hBEEFBEEF, 8'hC, 2'd0, 1'b0, 16'd0);
        push(1'b1, M_S, 64'h0, 8'h0C, 2'd0, 1'b0, 16'd0);
        nxt();
        store(5'd10, 64'hBEEF, 2'd1, 3'd3);
        push(1'b0, M_S, 64'h0, 8'hC, 2'd0, 1'b0, 16'd0);
        push(1'b1, M_S, 64'h0, 8'h0C, 2'd0, 1'b0, 16'd0);
        nxt();
        store(5'd10, 64'h11223344_55667788, 2'd2, 3'd4);
        push(1'b0, M_D | M_S, 64'h55667788, 8'hF, 2'd0, 1'b0, 16'd0);
        push(1'b1, M_D | M_S, 64'h55667788_55667788, 8'hF0, 2'd0, 1'b0, 16'd0);
        nxt();
        store(5'd10, 64'h11223344_55667788, 2'd3, 3'd5);
        push(1'b0, M_D | M_S, 64'h55667788, 8'hF, 2'd0, 1'b0, 16'd0);
        push(1'b1, M_D | M_S, 64'h11223344_55667788, 8'hFF, 2'd0, 1'b0, 16'd0);
        nxt();
        store(5'd10, 64'h5A, 2'd0, 3'd7);
        push(1'b0, M_S, 64'h0, 8'h8, 2'd0, 1'b0, 16'd0);
        push(1'b1, M_S, 64'h0, 8'h80, 2'd0, 1'b0, 16'd0);
        nxt();
        store(5'd10, 64'h5A, 2'd2, 3'd0);
        mem_is_store = 1'b0;
        push(1'b0, M_S, 64'h0, 8'h0, 2'd0, 1'b0, 16'd0);
        push(1'b1, M_S, 64'h0, 8'h0, 2'd0, 1'b0, 16'd0);
        nxt();

        // flush in WAIT together with the returning load
        do_reset();
        for (int i = 0; i < 2; i++) begin
            lp_valid = 1'b1;
            lp_rd    = 5'd9;
            store(5'd9, 64'h1, 2'd2, 3'd0);
            push(1'b0, M_T | M_C, 64'h0, 8'h0, 2'd0, 1'b1, 16'(i));
            nxt();
        end
        store(5'd9, 64'h1, 2'd2, 3'd0);
        wb(5'd9, 64'h77777777);
        flush = 1'b1;
        push(1'b0, M_T | M_C, 64'h0, 8'h0, 2'd0, 1'b1, 16'd2);
        nxt();
        store(5'd9, 64'h1, 2'd2, 3'd0);
        push(1'b0, M_D | M_F | M_T | M_C, 64'h77777777, 8'h0, 2'd2, 1'b0, 16'd2);
        push(1'b1, M_F | M_T, 64'h0, 8'h0, 2'd2, 1'b0, 16'd0);
        nxt();

        // x0 never forwards and never enters history
        do_reset();
        wb(5'd12, 64'h12);
        nxt();
        wb(5'd0, 64'h99);
        store(5'd0, 64'h5555AAAA, 2'd2, 3'd0);
        push(1'b0, M_D | M_F, 64'h5555AAAA, 8'h0, 2'd0, 1'b0, 16'd0);
        push(1'b1, M_F, 64'h0, 8'h0, 2'd0, 1'b0, 16'd0);
        nxt();
        store(5'd12, 64'h0, 2'd2, 3'd0);
        push(1'b0, M_D | M_F, 64'h12, 8'h0, 2'd2, 1'b0, 16'd0);
        push(1'b1, M_D | M_F, 64'h00000012_00000012, 8'h0, 2'd2, 1'b0, 16'd0);
        nxt();

        // asynchronous reset while waiting
        for (int i = 0; i < 2; i++) begin
            lp_valid = 1'b1;
            lp_rd    = 5'd9;
            store(5'd9, 64'h1, 2'd2, 3'd0);
            push(1'b0, M_T | M_C, 64'h0, 8'h0, 2'd0, 1'b1, 16'(i));
            if (i == 0) nxt();
        end
        @(negedge clk);
        #2;
        rst_n    = 1'b0;
        lp_valid = 1'b0;
        #1;
        chk("async_rst_stall", 64'(stall32), 64'h0);
        push(1'b0, M_T | M_C, 64'h0, 8'h0, 2'd0, 1'b0, 16'd0);
        push(1'b1, M_T | M_C, 64'h0, 8'h0, 2'd0, 1'b0, 16'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle();

        @(negedge clk);
        #1;
        chk("sb_empty", 64'(sb.size()), 64'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
